// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory access controller: FSM state encoding,
// access-size codes and the alignment rule used at request accept.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    CAPT  = 3'd2,
    MERGE = 3'd3,
    WR    = 3'd4,
    RESP  = 3'd5
  } lsu_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Bytes are always aligned; the reserved size code 2'b11 is treated as a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      default: mis = |addr_lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Little-endian lane handling: extracts and extends sub-word load data, and merges
// sub-word store data into the word read back for a read-modify-write.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
    load_o   = rdata_i;
    merge_o  = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o  = {{24{signed_i & byte_sel[7]}}, byte_sel};
        merge_o = rdata_i;
        merge_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        load_o  = {{16{signed_i & half_sel[15]}}, half_sel};
        merge_o = rdata_i;
        merge_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator for the processor data-memory port: one load/store at a time, word-indexed
// strobes held across the BRAM read path. Define LSU_SUBWORD_EN for byte/half accesses.
module mem_access_ctrl
  import lsu_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int WORD_IDX_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(RD_LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY - 1);

  lsu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  logic             req_ready_q, resp_valid_q, resp_err_q, mem_rd_q, mem_wr_q;
  logic [31:0]      resp_rdata_q, mem_addr_q, mem_wdata_q;

  logic [31:0] word_idx;
  logic [31:0] load_data, merge_data;
  logic        accept, misaligned, rmw_req;
  logic        unused_bits;

  assign word_idx = {{(32-WORD_IDX_W){1'b0}}, req_addr[WORD_IDX_W+1:2]};
  assign accept   = req_valid & req_ready_q;

`ifdef LSU_SUBWORD_EN
  logic [1:0] size_q;
  logic       signed_q;
  logic [1:0] addr_lo_q;

  lsu_byte_lane u_lane (
    .size_i    (size_q),
    .signed_i  (signed_q),
    .addr_lo_i (addr_lo_q),
    .rdata_i   (mem_rdata),
    .wdata_i   (mem_wdata_q),
    .load_o    (load_data),
    .merge_o   (merge_data)
  );

  assign misaligned  = is_misaligned(req_size, req_addr[1:0]);
  assign rmw_req     = req_we & ((req_size == SZ_BYTE) | (req_size == SZ_HALF));
  assign unused_bits = ^req_addr[31:WORD_IDX_W+2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      size_q    <= SZ_WORD;
      signed_q  <= 1'b0;
      addr_lo_q <= 2'b00;
    end else if (accept) begin
      size_q    <= req_size;
      signed_q  <= req_signed;
      addr_lo_q <= req_addr[1:0];
    end
  end
`else
  assign load_data   = mem_rdata;
  assign merge_data  = mem_wdata_q;
  assign misaligned  = is_misaligned(SZ_WORD, req_addr[1:0]);
  assign rmw_req     = 1'b0;
  assign unused_bits = ^{req_size, req_signed, req_addr[31:WORD_IDX_W+2]};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            req_ready_q  <= 1'b0;
            we_q         <= req_we;
            mem_addr_q   <= word_idx;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            if (req_we) mem_wdata_q <= req_wdata;
            if (misaligned) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (!req_we || rmw_req) begin
              state_q  <= RD;
              cnt_q    <= '0;
              mem_rd_q <= 1'b1;
            end else begin
              state_q  <= WR;
              mem_wr_q <= 1'b1;
            end
          end
        end
        // Counter parks at its last value; the strobe drops as we leave RD.
        RD: begin
          if (cnt_q == CNT_LAST) begin
            mem_rd_q <= 1'b0;
            state_q  <= we_q ? MERGE : CAPT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        CAPT: begin
          resp_rdata_q <= load_data;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        MERGE: begin
          mem_wdata_q <= merge_data;
          mem_wr_q    <= 1'b1;
          state_q     <= WR;
        end
        WR: begin
          mem_wr_q     <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
          req_ready_q  <= 1'b1;
          state_q      <= IDLE;
        end
        default: begin
          mem_rd_q    <= 1'b0;
          mem_wr_q    <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_rd     = mem_rd_q;
  assign mem_wr     = mem_wr_q;

endmodule
